// File: rtl/lpc_stage_sequencer_if.sv
// lpc_stage_sequencer_if
// Bundles the sequencer's handshake with the frame scheduler and the three
// LPC stage blocks.
//   master : the sequencer (drives stage starts, mux select, status).
//   slave  : scheduler/stage side (drives frame_start and stage dones).
// Signals:
//   frame_start                   one-cycle frame request
//   autocorr_done/lag_done/levinson_done   stage completions
//   autocorr_start/lag_start/levinson_start one-cycle stage starts
//   mux_sel[1:0]                  shared-pool owner (00 none, 01 AC, 10 LW, 11 LD)
//   busy, done                    frame in flight / frame finished pulse
//   timeout_err, overrun_err      sticky status
//   frame_count[15:0]             frames completed without timeout
interface lpc_stage_sequencer_if;
   logic        frame_start;
   logic        autocorr_done;
   logic        lag_done;
   logic        levinson_done;
   logic        autocorr_start;
   logic        lag_start;
   logic        levinson_start;
   logic [1:0]  mux_sel;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic        overrun_err;
   logic [15:0] frame_count;

   modport master (
      input  frame_start, autocorr_done, lag_done, levinson_done,
      output autocorr_start, lag_start, levinson_start, mux_sel,
             busy, done, timeout_err, overrun_err, frame_count
   );

   modport slave (
      output frame_start, autocorr_done, lag_done, levinson_done,
      input  autocorr_start, lag_start, levinson_start, mux_sel,
             busy, done, timeout_err, overrun_err, frame_count
   );
endinterface

// File: rtl/lpc_stage_sequencer.sv
// lpc_stage_sequencer
// Runs autocorrelation -> lag window -> Levinson-Durbin for one frame, owning
// the shared math/scratch mux select, with a per-stage watchdog and overrun
// detection.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   bus      lpc_stage_sequencer_if.master (see interface header)
// Parameter:
//   TIMEOUT  cycles a stage may wait for its done before the frame aborts
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | no frame, pool unowned, waiting for frame_start
// AC_START | autocorr start pulse, pool owned by autocorr
// AC_WAIT  | waiting for autocorr_done, watchdog running
// LW_START | lag-window start pulse, pool owned by lag window
// LW_WAIT  | waiting for lag_done, watchdog running
// LD_START | Levinson start pulse, pool owned by Levinson
// LD_WAIT  | waiting for levinson_done, watchdog running
// DONE     | frame complete pulse, count frame
// ERROR    | watchdog abort, done pulse, flag timeout
module lpc_stage_sequencer #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   lpc_stage_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, AC_START, AC_WAIT, LW_START, LW_WAIT, LD_START, LD_WAIT, DONE, ERROR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] wdog;
   logic [15:0] frame_cnt;
   logic        wdog_exp;
   logic        is_wait;
   logic [1:0]  mux_nxt;

   assign wdog_exp        = (wdog == 16'(TIMEOUT - 1));
   assign bus.frame_count = frame_cnt;

   // Dones are only looked at in the owning stage's WAIT state, so a done
   // left high from an earlier stage or frame cannot skip a START.
   always_comb begin
      state_nxt = state;
      is_wait   = 1'b0;
      unique case (state)
         IDLE:     if (bus.frame_start) state_nxt = AC_START;
         AC_START: state_nxt = AC_WAIT;
         AC_WAIT: begin
            is_wait = 1'b1;
            if (bus.autocorr_done) state_nxt = LW_START;
            else if (wdog_exp)     state_nxt = ERROR;
         end
         LW_START: state_nxt = LW_WAIT;
         LW_WAIT: begin
            is_wait = 1'b1;
            if (bus.lag_done)  state_nxt = LD_START;
            else if (wdog_exp) state_nxt = ERROR;
         end
         LD_START: state_nxt = LD_WAIT;
         LD_WAIT: begin
            is_wait = 1'b1;
            if (bus.levinson_done) state_nxt = DONE;
            else if (wdog_exp)     state_nxt = ERROR;
         end
         DONE:     state_nxt = IDLE;
         ERROR:    state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mux_nxt = 2'b00;
      unique case (state_nxt)
         AC_START, AC_WAIT: mux_nxt = 2'b01;
         LW_START, LW_WAIT: mux_nxt = 2'b10;
         LD_START, LD_WAIT: mux_nxt = 2'b11;
         default:           mux_nxt = 2'b00;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they describe, with no input-to-output combinational path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state              <= IDLE;
         wdog               <= '0;
         frame_cnt          <= '0;
         bus.autocorr_start <= 1'b0;
         bus.lag_start      <= 1'b0;
         bus.levinson_start <= 1'b0;
         bus.mux_sel        <= 2'b00;
         bus.busy           <= 1'b0;
         bus.done           <= 1'b0;
         bus.timeout_err    <= 1'b0;
         bus.overrun_err    <= 1'b0;
      end else begin
         state              <= state_nxt;
         bus.autocorr_start <= (state_nxt == AC_START);
         bus.lag_start      <= (state_nxt == LW_START);
         bus.levinson_start <= (state_nxt == LD_START);
         bus.mux_sel        <= mux_nxt;
         bus.busy           <= (state_nxt != IDLE);
         bus.done           <= (state_nxt == DONE) || (state_nxt == ERROR);

         // Watchdog restarts at 0 on every WAIT entry.
         if (is_wait && (state_nxt == state)) wdog <= wdog + 16'd1;
         else                                 wdog <= '0;

         if (bus.frame_start) begin
            if (state == IDLE) begin
               bus.timeout_err <= 1'b0;
               bus.overrun_err <= 1'b0;
            end else begin
               bus.overrun_err <= 1'b1;
            end
         end

         if (state_nxt == ERROR) bus.timeout_err <= 1'b1;
         if (state_nxt == DONE)  frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule
